// File: rtl/core_pkg.sv
// core_pkg: shared opcodes, state encoding, field positions and control bundle for the RISC controller
package core_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;
  localparam int FLD_W   = 4;
  localparam int IMM_W   = 8;
  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_IMM = 2'd1;
  localparam logic [1:0] WSEL_MEM = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef struct packed {
    logic             is_alu;
    logic             is_ldi;
    logic             is_st;
    logic             is_ld;
    logic             is_jmp;
    logic             is_beqz;
    logic             is_halt;
    logic             illegal;
    logic [3:0]       rd;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic [1:0]       wsel;
    logic [1:0]       alu_op;
    logic [IMM_W-1:0] imm;
  } ctrl_t;
endpackage

// File: rtl/core_decode.sv
// core_decode: combinational instruction-register to control-bundle decode
module core_decode import core_pkg::*; (
  input  logic [15:0] ir,
  output ctrl_t       ctrl
);
  logic [3:0] op;
  assign op = ir[OP_LSB +: FLD_W];
  always_comb begin
    ctrl.is_alu  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    ctrl.is_ldi  = op == OP_LDI;
    ctrl.is_st   = op == OP_ST;
    ctrl.is_ld   = op == OP_LD;
    ctrl.is_jmp  = op == OP_JMP;
    ctrl.is_beqz = op == OP_BEQZ;
    ctrl.is_halt = op == OP_HALT;
    ctrl.illegal = !(ctrl.is_alu || ctrl.is_ldi || ctrl.is_st || ctrl.is_ld ||
                     ctrl.is_jmp || ctrl.is_beqz || ctrl.is_halt);
    ctrl.rd      = ir[RD_LSB +: FLD_W];
    ctrl.ra      = (ctrl.is_st || ctrl.is_beqz) ? ir[RD_LSB +: FLD_W] : ir[RS1_LSB +: FLD_W];
    ctrl.rb      = ir[RS2_LSB +: FLD_W];
    ctrl.wsel    = ctrl.is_ldi ? WSEL_IMM : ctrl.is_ld ? WSEL_MEM : WSEL_ALU;
    ctrl.alu_op  = ctrl.is_alu ? op[1:0] : ALU_ADD;
    ctrl.imm     = ir[IMM_LSB +: IMM_W];
  end
endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle fetch/decode/exec/mem/wb controller owning PC and IR
module core_ctrl_fsm import core_pkg::*; #(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  input  logic [15:0]       instr,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  input  logic              rf_a_zero,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [1:0]        rf_wsel,
  output logic [7:0]        imm,
  output logic [1:0]        alu_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);
  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic             illegal_q, illegal_d;
  ctrl_t            dec;
  core_decode u_decode (.ir(ir_q), .ctrl(dec));
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_d    = instr;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d   = (dec.illegal || dec.is_halt) ? S_HALT :
                    dec.is_jmp                   ? S_FETCH :
                    dec.is_ldi                   ? S_WB :
                    (dec.is_st || dec.is_ld)     ? S_MEM : S_EXEC;
        pc_d      = dec.is_jmp ? PC_W'(dec.imm) : pc_q;
        illegal_d = illegal_q | dec.illegal;
      end
      S_EXEC: begin
        state_d = dec.is_beqz ? S_FETCH : S_WB;
        pc_d    = (dec.is_beqz && rf_a_zero) ? PC_W'(dec.imm) : pc_q;
      end
      S_MEM:    state_d = !mem_ready ? S_MEM : dec.is_ld ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  assign pc         = pc_q;
  assign rf_raddr_a = dec.ra;
  assign rf_raddr_b = dec.rb;
  assign rf_we      = state_q == S_WB;
  assign rf_waddr   = dec.rd;
  assign rf_wsel    = dec.wsel;
  assign imm        = dec.imm;
  assign alu_op     = dec.alu_op;
  assign mem_req    = state_q == S_MEM;
  assign mem_we     = mem_req && dec.is_st;
  assign mem_addr   = ADDR_W'(dec.imm);
  assign busy       = !(state_q == S_IDLE || state_q == S_HALT);
  assign halted     = state_q == S_HALT;
  assign illegal    = illegal_q;
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: directed programs checked cycle-by-cycle against an instruction-level timing model
module tb_core_ctrl_fsm;
  localparam int N = 64;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] pc, imm, mem_addr;
  logic [15:0] instr;
  logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [1:0] rf_wsel, alu_op;
  logic rf_a_zero, rf_we, mem_req, mem_we, mem_ready, busy, halted, illegal;
  logic [15:0] rom [256];
  int stall, cnt;
  logic zero;
  int checks = 0, errors = 0;
  core_ctrl_fsm #(.PC_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_a_zero(rf_a_zero),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .imm(imm), .alu_op(alu_op),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .busy(busy), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign instr     = rom[pc];
  assign rf_a_zero = zero;
  assign mem_ready = cnt >= stall;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 0;
    else if (mem_req) cnt <= mem_ready ? 0 : cnt + 1;
  logic       e_we [N], e_req [N], e_mwe [N], e_ra_v [N], e_alu_v [N], e_pc_v [N];
  logic       e_busy [N], e_halt [N], e_ill [N];
  logic [3:0] e_wa [N], e_ra [N], e_rb [N];
  logic [1:0] e_ws [N], e_alu [N];
  logic [7:0] e_imm [N], e_ma [N], e_pc [N];
  int halt_c, ncyc, cyc;
  logic chk_en = 1'b0;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic put_we(input int t, input logic [3:0] rd, input logic [1:0] ws, input logic [7:0] iv);
    if (t < N) begin
      e_we[t] = 1'b1; e_wa[t] = rd; e_ws[t] = ws; e_imm[t] = iv;
    end
  endtask
  task automatic build(input int n);
    logic [7:0] p;
    logic [15:0] w;
    logic [3:0] op, rd;
    logic ill;
    int c;
    for (int t = 0; t < N; t++) begin
      e_we[t] = 0; e_req[t] = 0; e_mwe[t] = 0; e_ra_v[t] = 0; e_alu_v[t] = 0; e_pc_v[t] = 0;
      e_busy[t] = 0; e_halt[t] = 0; e_ill[t] = 0; e_wa[t] = 0; e_ra[t] = 0; e_rb[t] = 0;
      e_ws[t] = 0; e_alu[t] = 0; e_imm[t] = 0; e_ma[t] = 0; e_pc[t] = 0;
    end
    p = 0; c = 1; halt_c = n; ill = 0;
    while (c < n) begin
      w = rom[p]; op = w[15:12]; rd = w[11:8];
      e_pc_v[c] = 1'b1; e_pc[c] = p;
      p = p + 8'd1;
      if (op < 4) begin
        for (int k = 2; k <= 3; k++)
          if (c + k < N) begin
            e_alu_v[c+k] = 1'b1; e_alu[c+k] = op[1:0];
            e_ra_v[c+k] = 1'b1; e_ra[c+k] = w[7:4]; e_rb[c+k] = w[3:0];
          end
        put_we(c + 3, rd, 2'd0, w[7:0]);
        c += 4;
      end else if (op == 4) begin
        put_we(c + 2, rd, 2'd1, w[7:0]);
        c += 3;
      end else if (op == 5 || op == 6) begin
        for (int k = 0; k <= stall; k++)
          if (c + 2 + k < N) begin
            e_req[c+2+k] = 1'b1; e_mwe[c+2+k] = (op == 5); e_ma[c+2+k] = w[7:0];
            if (op == 5) begin e_ra_v[c+2+k] = 1'b1; e_ra[c+2+k] = rd; end
          end
        if (op == 6) begin
          put_we(c + 3 + stall, rd, 2'd2, w[7:0]);
          c += 4 + stall;
        end else c += 3 + stall;
      end else if (op == 7) begin
        p = w[7:0];
        c += 2;
      end else if (op == 8) begin
        if (c + 2 < N) begin e_ra_v[c+2] = 1'b1; e_ra[c+2] = rd; end
        if (zero) p = w[7:0];
        c += 3;
      end else begin
        halt_c = c + 2;
        ill = (op != 4'hF);
        break;
      end
    end
    for (int t = 1; t < n; t++) begin
      e_busy[t] = t < halt_c;
      e_halt[t] = t >= halt_c;
      e_ill[t]  = (t >= halt_c) && ill;
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      if (cyc < ncyc) begin
        chk("rf_we", rf_we, e_we[cyc]);
        if (e_we[cyc]) begin
          chk("rf_waddr", rf_waddr, e_wa[cyc]);
          chk("rf_wsel", rf_wsel, e_ws[cyc]);
          if (e_ws[cyc] == 2'd1) chk("imm", imm, e_imm[cyc]);
        end
        chk("mem_req", mem_req, e_req[cyc]);
        if (e_req[cyc]) begin
          chk("mem_we", mem_we, e_mwe[cyc]);
          chk("mem_addr", mem_addr, e_ma[cyc]);
        end
        if (e_ra_v[cyc]) chk("rf_raddr_a", rf_raddr_a, e_ra[cyc]);
        if (e_alu_v[cyc]) begin
          chk("alu_op", alu_op, e_alu[cyc]);
          chk("rf_raddr_b", rf_raddr_b, e_rb[cyc]);
        end
        if (e_pc_v[cyc]) chk("fetch_pc", pc, e_pc[cyc]);
        chk("busy", busy, e_busy[cyc]);
        chk("halted", halted, e_halt[cyc]);
        chk("illegal", illegal, e_ill[cyc]);
      end
      cyc++;
    end else cyc = 1;
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask
  task automatic run(input int n);
    build(n);
    ncyc = n;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_req", mem_req, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk_en = 1'b1;
    repeat (n - 1) @(negedge clk);
    #1 chk_en = 1'b0;
  endtask
  initial begin
    int found, nreq;
    clear_rom();
    stall = 0; zero = 0;
    rom[0] = 16'h4105; rom[1] = 16'h420A; rom[2] = 16'h0312; rom[3] = 16'h5300; rom[4] = 16'hF000;
    run(24);
    chk("m_halt_c", halt_c, 16);
    chk("m_we3", {e_we[3], e_wa[3], 2'b0, e_ws[3]}, {1'b1, 4'd1, 2'b0, 2'd1});
    chk("m_we6", {e_we[6], e_wa[6], 2'b0, e_ws[6]}, {1'b1, 4'd2, 2'b0, 2'd1});
    chk("m_we10", {e_we[10], e_wa[10], 2'b0, e_ws[10]}, {1'b1, 4'd3, 2'b0, 2'd0});
    chk("m_req", {e_req[12], e_req[13], e_mwe[13], e_req[14]}, 4'b0110);
    chk("p1_pc", pc, 8'd5);
    chk("p1_halted", halted, 1);
    clear_rom();
    stall = 3;
    rom[0] = 16'h6533;
    run(16);
    nreq = 0;
    for (int t = 0; t < N; t++) nreq += int'(e_req[t]);
    chk("m_ld_reqs", nreq, 4);
    chk("m_ld_we7", {e_we[7], e_wa[7], 2'b0, e_ws[7]}, {1'b1, 4'd5, 2'b0, 2'd2});
    chk("ld_pc", pc, 8'd2);
    clear_rom();
    stall = 0; zero = 1;
    rom[0] = 16'h8420;
    run(12);
    chk("m_beqz_t", e_pc[4], 8'h20);
    chk("beqz_t_pc", pc, 8'h21);
    zero = 0;
    run(12);
    chk("m_beqz_nt", e_pc[4], 8'h01);
    chk("beqz_nt_pc", pc, 8'h02);
    clear_rom();
    rom[0] = 16'h70FE; rom[8'hFE] = 16'h4707; rom[8'hFF] = 16'h0000;
    run(40);
    chk("m_wrap_ff", e_pc[6], 8'hFF);
    chk("m_wrap_00", e_pc[10], 8'h00);
    chk("m_wrap_fe", e_pc[12], 8'hFE);
    clear_rom();
    rom[0] = 16'hA000;
    run(10);
    chk("m_ill", {e_halt[2], e_halt[3], e_ill[3]}, 3'b011);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("ill_rf_we", rf_we, 0);
      chk("ill_mem_req", mem_req, 0);
    end
    chk("ill_halted", halted, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_busy", busy, 0);
    chk("ill_pc", pc, 8'd1);
    clear_rom();
    stall = 8;
    rom[0] = 16'h5110;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (mem_req) found = 1;
    end
    chk("wait_mem_req", found, 1);
    chk("mid_mem_we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_mem_we", mem_we, 0);
    chk("async_pc", pc, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_pc", pc, 0);
      chk("post_rst_mem_req", mem_req, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
